poly_acc_reduce: RTL and testbench
==================================

Name: poly_acc_reduce

Overview:
- Downstream stage of the basemul/tomont block. Consumes its coefficient-pair stream (dout_1, dout_2, out_index) for K successive polynomial products and accumulates them in a local dual-port RAM, i.e. the sum over i of a_i*b_i for polyvec_basemul_acc.
- After the last polynomial, Barrett-reduces all 256 coefficients in place, then streams the result out in pairs.

Parameters:
- DEPTH, 8, address width; 2^DEPTH coefficients per polynomial, processed as pairs at even addresses.
- KMAX, 4, maximum number of accumulated polynomials.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- set  input  1  global enable; when low, all state, RAM writes and outputs hold
- start  input  1  pulse; latches k_num and begins a new accumulation; ignored unless IDLE
- k_num  input  3  polynomials to accumulate; 0 is treated as 1, values above KMAX are treated as KMAX
- in_valid  input  1  input pair valid
- in_ready  output  1  high in ACC only; a transfer happens on in_valid & in_ready & set
- din_1  input  16  signed even coefficient
- din_2  input  16  signed odd coefficient
- in_index  input  DEPTH  even address of the pair
- readout  input  1  request result stream
- dout_1  output  16  signed reduced even coefficient; 0 when out_valid is low
- dout_2  output  16  signed reduced odd coefficient; 0 when out_valid is low
- out_index  output  DEPTH  address of the current output pair; 0 when out_valid is low
- out_valid  output  1  output pair valid
- busy  output  1  high in every state except IDLE
- done  output  1  high in DONE and READOUT

Behaviour:
- Reset: state IDLE. poly_cnt, red_idx, rd_idx and k_lat are 0. in_ready, out_valid, busy and done are 0. dout_1, dout_2 and out_index are 0. RAM contents are don't-care.
- States: IDLE -> ACC -> REDUCE -> DONE -> READOUT -> IDLE.
- IDLE:
  - start & set latches k_lat (clamped to 1..KMAX) and clears poly_cnt; next state ACC.
- ACC, accumulation:
  - Accepted pair at cycle N: RAM read at in_index and in_index+1 is issued at N. Data returns at N+1. At N+1, write (din + RAM) if poly_cnt > 0, or din alone if poly_cnt == 0 (first polynomial overwrites stale data).
  - Inputs are registered for the write stage.
  - Back-to-back transfers are allowed. Addresses differ by 2, so there is no RMW hazard.
  - Addition is 16-bit two's complement. No overflow occurs for |din| < q and K <= 4.
  - When an accepted in_index equals 2^DEPTH-2, poly_cnt increments.
  - When poly_cnt reaches k_lat, the state moves to REDUCE after the final write completes. in_ready drops the cycle after that last transfer.
- REDUCE:
  - Walk red_idx = 0, 2, ..., 2^DEPTH-2. For each pair: read, then Barrett on both lanes, then write back to the same address. The pipeline is 3 stages and one pair enters per cycle.
  - Barrett: v = 20159, t = (v*a + 2^25) >>> 26 (signed, arithmetic shift), r = a - t*3329. Products are 32-bit signed. Result r lies in [-1664, 1664].
  - After the last write-back, state goes to DONE. Duration is 2^(DEPTH-1) + 3 cycles.
- DONE:
  - done = 1; waits for readout.
- READOUT:
  - While readout is high, read rd_idx and advance rd_idx by 2 each cycle.
  - Data appears one cycle after the address is issued, with out_valid = 1 and out_index = the pair address.
  - Deasserting readout pauses the stream: out_valid = 0 the following cycle and rd_idx holds.
  - After pair 2^DEPTH-2 is output, the state returns to IDLE and done falls.
- Inputs outside their valid state:
  - in_valid outside ACC is ignored.
  - start outside IDLE is ignored.
  - readout outside DONE/READOUT is ignored.
- Reset mid-operation: reset in any state returns to IDLE next cycle with reset values. No partial output is produced.
- Simultaneous start and readout in IDLE: start wins and readout is ignored.

Test Plan:
- Reset asserted during ACC after 10 pairs -> next cycle busy=0, in_ready=0, out_valid=0, dout_1/dout_2/out_index=0; a new start with k_num=1 works from clean state.
- k_num=2, poly0 all pairs (100,-200), poly1 all pairs (3000,1000) -> readout yields (3100-3329=-229, 800) at every even index 0..254, out_valid for 128 consecutive cycles.
- k_num=1, pairs at index 0/2/4/6 = (3329,-3329), (1665,-1665), (1664,13315), (0,-13315); rest 0 -> outputs (0,0), (-1664,1664), (1664,-1), (0,1).
- k_num=4, each poly pair 0 = (3328,3328) -> accumulated 13312 -> reduced (-4,-4) at index 0.
- Back-pressure/pausing: in_valid toggled every other cycle through ACC -> sums correct. readout dropped for 3 cycles mid-stream -> out_valid low for those 3 cycles, then the stream resumes at the next unsent index with no skipped or duplicated index.
- k_num=0 and k_num=7 -> behave as 1 and 4 (DONE after 128 and 512 accepted pairs respectively). start pulsed in REDUCE -> ignored, result unchanged.

Source files
------------

// File: rtl/poly_acc_reduce.sv
// Polynomial accumulator: sums K basemul coefficient-pair streams into a local
// two-bank RAM, Barrett-reduces every coefficient in place, then streams the
// reduced polynomial out in pairs.
module poly_acc_reduce #(
  parameter int DEPTH = 8,
  parameter int KMAX  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             start,
  input  logic [2:0]       k_num,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      din_1,
  input  logic [15:0]      din_2,
  input  logic [DEPTH-1:0] in_index,
  input  logic             readout,
  output logic [15:0]      dout_1,
  output logic [15:0]      dout_2,
  output logic [DEPTH-1:0] out_index,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int PW    = DEPTH - 1;
  localparam int NPAIR = 2 ** PW;
  localparam logic [DEPTH-1:0]   LAST_IDX    = DEPTH'(2 ** DEPTH - 2);
  localparam logic [PW-1:0]      LAST_PAIR   = '1;
  localparam logic signed [31:0] BARRETT_V   = 32'sd20159;
  localparam logic signed [31:0] BARRETT_RND = 32'sd33554432;
  localparam logic signed [31:0] KYBER_Q     = 32'sd3329;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_REDUCE,
    S_DONE,
    S_READOUT
  } state_t;

  state_t state_q, state_d;

  // Control registers
  logic [2:0]       k_lat_q;
  logic [2:0]       poly_cnt_q;
  logic [DEPTH-1:0] red_idx_q;
  logic [DEPTH-1:0] rd_idx_q;
  logic             red_active_q;
  logic             rd_last_q;

  // Accumulation write stage (inputs registered alongside the RAM read)
  logic             wr_v_q;
  logic             wr_first_q;
  logic [PW-1:0]    wr_pair_q;
  logic [15:0]      wr_d1_q;
  logic [15:0]      wr_d2_q;

  // Reduction pipeline: read -> multiply -> reduce -> write back
  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [PW-1:0]    s1_pair_q, s2_pair_q, s3_pair_q;
  logic signed [31:0] prod_e_q, prod_o_q;
  logic signed [31:0] prod_e_d, prod_o_d;
  logic signed [15:0] a_e_q, a_o_q;
  logic signed [31:0] t_e, t_o;
  logic signed [15:0] res_e_d, res_o_d;
  logic signed [15:0] res_e_q, res_o_q;

  // Readout stage
  logic             out_v_q;
  logic [DEPTH-1:0] out_idx_q;

  // Two-bank RAM: even lane and odd lane share one pair address
  logic [15:0]        mem_e [NPAIR];
  logic [15:0]        mem_o [NPAIR];
  logic signed [15:0] rdata_e_q, rdata_o_q;
  logic [PW-1:0]      raddr;
  logic [PW-1:0]      waddr;
  logic               we;
  logic [15:0]        wdata_e, wdata_o;

  logic       in_fire;
  logic       red_issue;
  logic       rd_issue;
  logic       start_ok;
  logic [2:0] k_clamp;

  assign in_fire   = in_valid & in_ready & set;
  assign red_issue = (state_q == S_REDUCE) & red_active_q;
  assign rd_issue  = ((state_q == S_DONE) | (state_q == S_READOUT)) & readout & ~rd_last_q;
  assign start_ok  = (state_q == S_IDLE) & start;

  // Clamp requested polynomial count into 1..KMAX
  always_comb begin
    k_clamp = k_num;
    if (k_num == 3'd0) begin
      k_clamp = 3'd1;
    end else if (k_num > 3'(KMAX)) begin
      k_clamp = 3'(KMAX);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (set) begin
      state_q <= state_d;
    end
  end

  // FSM next-state and status outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ACC;
      end
      S_ACC: begin
        // Once the final polynomial is counted, the cycle that follows is the
        // last pending write; leave ACC exactly as it lands.
        in_ready = (poly_cnt_q != k_lat_q);
        if (poly_cnt_q == k_lat_q) state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (s3_v_q && (s3_pair_q == LAST_PAIR)) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (rd_issue) state_d = S_READOUT;
      end
      S_READOUT: begin
        done = 1'b1;
        if (out_v_q && (out_idx_q == LAST_IDX)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Polynomial count, reduction and readout address walkers
  always_ff @(posedge clk) begin
    if (reset) begin
      k_lat_q      <= '0;
      poly_cnt_q   <= '0;
      red_idx_q    <= '0;
      rd_idx_q     <= '0;
      red_active_q <= 1'b0;
      rd_last_q    <= 1'b0;
    end else if (set) begin
      if (start_ok) begin
        k_lat_q    <= k_clamp;
        poly_cnt_q <= '0;
        red_idx_q  <= '0;
        rd_idx_q   <= '0;
        rd_last_q  <= 1'b0;
      end
      if (in_fire && (in_index == LAST_IDX)) begin
        poly_cnt_q <= poly_cnt_q + 3'd1;
      end
      if ((state_q == S_ACC) && (state_d == S_REDUCE)) begin
        red_active_q <= 1'b1;
      end
      if (red_issue) begin
        red_idx_q <= red_idx_q + DEPTH'(2);
        if (red_idx_q == LAST_IDX) red_active_q <= 1'b0;
      end
      if (rd_issue) begin
        rd_idx_q <= rd_idx_q + DEPTH'(2);
        if (rd_idx_q == LAST_IDX) rd_last_q <= 1'b1;
      end
    end
  end

  // Register accepted input pairs to meet the RAM read data one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_v_q <= 1'b0;
    end else if (set) begin
      wr_v_q <= in_fire;
      if (in_fire) begin
        wr_pair_q  <= in_index[DEPTH-1:1];
        wr_d1_q    <= din_1;
        wr_d2_q    <= din_2;
        wr_first_q <= (poly_cnt_q == 3'd0);
      end
    end
  end

  // Barrett arithmetic: multiply on RAM data, then round-shift and subtract
  always_comb begin
    prod_e_d = 32'(rdata_e_q) * BARRETT_V;
    prod_o_d = 32'(rdata_o_q) * BARRETT_V;
    t_e      = (prod_e_q + BARRETT_RND) >>> 26;
    t_o      = (prod_o_q + BARRETT_RND) >>> 26;
    res_e_d  = a_e_q - 16'(t_e * KYBER_Q);
    res_o_d  = a_o_q - 16'(t_o * KYBER_Q);
  end

  // Reduction pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else if (set) begin
      s1_v_q    <= red_issue;
      s1_pair_q <= red_idx_q[DEPTH-1:1];
      s2_v_q    <= s1_v_q;
      s2_pair_q <= s1_pair_q;
      prod_e_q  <= prod_e_d;
      prod_o_q  <= prod_o_d;
      a_e_q     <= rdata_e_q;
      a_o_q     <= rdata_o_q;
      s3_v_q    <= s2_v_q;
      s3_pair_q <= s2_pair_q;
      res_e_q   <= res_e_d;
      res_o_q   <= res_o_d;
    end
  end

  // RAM port muxing: read address by phase, write from ACC or REDUCE stage
  always_comb begin
    case (state_q)
      S_REDUCE:          raddr = red_idx_q[DEPTH-1:1];
      S_DONE, S_READOUT: raddr = rd_idx_q[DEPTH-1:1];
      default:           raddr = in_index[DEPTH-1:1];
    endcase
    we      = 1'b0;
    waddr   = wr_pair_q;
    wdata_e = wr_d1_q;
    wdata_o = wr_d2_q;
    if (wr_v_q) begin
      we      = 1'b1;
      waddr   = wr_pair_q;
      wdata_e = wr_first_q ? wr_d1_q : wr_d1_q + rdata_e_q;
      wdata_o = wr_first_q ? wr_d2_q : wr_d2_q + rdata_o_q;
    end else if (s3_v_q) begin
      we      = 1'b1;
      waddr   = s3_pair_q;
      wdata_e = res_e_q;
      wdata_o = res_o_q;
    end
  end

  // Coefficient RAM with registered read data
  always_ff @(posedge clk) begin
    if (set) begin
      if (we) begin
        mem_e[waddr] <= wdata_e;
        mem_o[waddr] <= wdata_o;
      end
      rdata_e_q <= mem_e[raddr];
      rdata_o_q <= mem_o[raddr];
    end
  end

  // Output valid/index track the readout address issued one cycle earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q   <= 1'b0;
      out_idx_q <= '0;
    end else if (set) begin
      out_v_q <= rd_issue;
      if (rd_issue) out_idx_q <= rd_idx_q;
    end
  end

  assign out_valid = out_v_q;
  assign dout_1    = out_v_q ? rdata_e_q : '0;
  assign dout_2    = out_v_q ? rdata_o_q : '0;
  assign out_index = out_v_q ? out_idx_q : '0;

endmodule

// File: tb/tb_poly_acc_reduce.sv
// Bench for poly_acc_reduce: table-driven vectors plus an output scoreboard.
module tb_poly_acc_reduce;

  localparam int NPAIR = 128;

  logic        clk = 1'b0;
  logic        reset, set, start;
  logic [2:0]  k_num;
  logic        in_valid, in_ready;
  logic [15:0] din_1, din_2;
  logic [7:0]  in_index;
  logic        readout;
  logic [15:0] dout_1, dout_2;
  logic [7:0]  out_index;
  logic        out_valid, busy, done;

  always #5 clk = ~clk;

  poly_acc_reduce #(.DEPTH(8), .KMAX(4)) dut (
    .clk(clk), .reset(reset), .set(set), .start(start), .k_num(k_num),
    .in_valid(in_valid), .in_ready(in_ready), .din_1(din_1), .din_2(din_2),
    .in_index(in_index), .readout(readout), .dout_1(dout_1), .dout_2(dout_2),
    .out_index(out_index), .out_valid(out_valid), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int idx; int e; int o; } pair_t;
  typedef struct { int idx; int d1; int d2; int x1; int x2; } vec_t;

  pair_t sb_q[$];
  vec_t  tv[4];
  int    acc_e[NPAIR];
  int    acc_o[NPAIR];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int barrett(input int a);
    longint t;
    t = (longint'(a) * 64'sd20159 + 64'sd33554432) >>> 26;
    return a - int'(t) * 3329;
  endfunction

  // Scoreboard: every valid output pair must match the head of the queue
  always @(negedge clk) begin
    pair_t x;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious out_valid", int'(out_valid), 0);
      end else begin
        x = sb_q.pop_front();
        check("out_index", int'(out_index), x.idx);
        check("dout_1", int'($signed(dout_1)), x.e);
        check("dout_2", int'($signed(dout_2)), x.o);
      end
    end
  end

  task automatic pulse_start(input logic [2:0] k);
    k_num = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input int idx, input int e, input int o, input int p, input bit gap);
    int w;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_index = 8'(idx);
    din_1    = 16'(e);
    din_2    = 16'(o);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) check("in_ready wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (p == 0) begin
      acc_e[idx/2] = e;
      acc_o[idx/2] = o;
    end else begin
      acc_e[idx/2] += e;
      acc_o[idx/2] += o;
    end
  endtask

  task automatic send_poly(input int p, input int mode, input bit gap);
    for (int i = 0; i < NPAIR; i++) begin
      int e, o;
      e = 0;
      o = 0;
      case (mode)
        1: begin e = 100;  o = -200; end
        2: begin e = 3000; o = 1000; end
        3: for (int j = 0; j < 4; j++)
             if (tv[j].idx == 2*i) begin e = tv[j].d1; o = tv[j].d2; end
        4: if (i == 0) begin e = 3328; o = 3328; end
        5: begin
             e = int'($urandom_range(6656)) - 3328;
             o = int'($urandom_range(6656)) - 3328;
           end
        6: begin e = i*13 - 800; o = 1000 - i*7; end
        default: ;
      endcase
      send_pair(2*i, e, o, p, gap);
    end
  endtask

  task automatic finish_acc(input int lat);
    int c;
    check("in_ready low after last pair", int'(in_ready), 0);
    c = 0;
    while (!done && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    if (lat < 0) check("done reached", int'(done), 1);
    else         check("done latency", c, lat);
  endtask

  task automatic push_model();
    for (int i = 0; i < NPAIR; i++) sb_q.push_back('{2*i, barrett(acc_e[i]), barrett(acc_o[i])});
  endtask

  task automatic push_const(input int e, input int o);
    for (int i = 0; i < NPAIR; i++) sb_q.push_back('{2*i, e, o});
  endtask

  task automatic push_table();
    for (int i = 0; i < NPAIR; i++) begin
      int e, o;
      e = 0;
      o = 0;
      for (int j = 0; j < 4; j++)
        if (tv[j].idx == 2*i) begin e = tv[j].x1; o = tv[j].x2; end
      sb_q.push_back('{2*i, e, o});
    end
  endtask

  task automatic read_all(input int pause_at, input int span);
    int cyc, first, last;
    cyc = 0; first = -1; last = -1;
    readout = 1'b1;
    while (sb_q.size() != 0 && cyc < 600) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
      if (cyc == pause_at) begin
        readout = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("out_valid while paused", int'(out_valid), 0);
          cyc++;
        end
        readout = 1'b1;
      end
    end
    readout = 1'b0;
    if (sb_q.size() != 0) begin
      check("stream drained", sb_q.size(), 0);
      sb_q.delete();
    end
    check("stream span", last - first + 1, span);
    check("done low after stream", int'(done), 0);
    check("busy low after stream", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 3329,  -3329,  0,     0};
    tv[1] = '{2, 1665,  -1665,  -1664, 1664};
    tv[2] = '{4, 1664,  13315,  1664,  -1};
    tv[3] = '{6, 0,     -13315, 0,     1};

    reset = 1'b1; set = 1'b1; start = 1'b0; k_num = 3'd0;
    in_valid = 1'b0; din_1 = '0; din_2 = '0; in_index = '0; readout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset in_ready", int'(in_ready), 0);
    check("reset done", int'(done), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset dout_1", int'(dout_1), 0);
    check("reset dout_2", int'(dout_2), 0);
    check("reset out_index", int'(out_index), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of accumulation
    pulse_start(3'd2);
    check("in_ready in ACC", int'(in_ready), 1);
    check("busy in ACC", int'(busy), 1);
    for (int i = 0; i < 10; i++) send_pair(2*i, 7, 9, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", int'(busy), 0);
    check("midreset in_ready", int'(in_ready), 0);
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset dout_1", int'(dout_1), 0);
    check("midreset dout_2", int'(dout_2), 0);
    check("midreset out_index", int'(out_index), 0);
    readout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("readout ignored in IDLE", int'(out_valid), 0);
    check("readout in IDLE keeps idle", int'(busy), 0);
    readout = 1'b0;

    // Table vectors, k_num = 1, clean start after reset
    pulse_start(3'd1);
    send_poly(0, 3, 1'b0);
    finish_acc(132);
    push_table();
    read_all(-1, 128);

    // k_num = 2 constant polynomials
    pulse_start(3'd2);
    send_poly(0, 1, 1'b0);
    check("in_ready between polys", int'(in_ready), 1);
    send_poly(1, 2, 1'b0);
    finish_acc(132);
    push_const(-229, 800);
    read_all(-1, 128);

    // k_num = 4 on pair 0; start and a set-low pause during REDUCE
    pulse_start(3'd4);
    for (int p = 0; p < 4; p++) send_poly(p, 4, 1'b0);
    check("in_ready low after k=4", int'(in_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    check("busy in REDUCE", int'(busy), 1);
    check("done low in REDUCE", int'(done), 0);
    pulse_start(3'd1);
    set = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy held with set low", int'(busy), 1);
    check("done held with set low", int'(done), 0);
    set = 1'b1;
    finish_acc(-1);
    sb_q.push_back('{0, -4, -4});
    for (int i = 1; i < NPAIR; i++) sb_q.push_back('{2*i, 0, 0});
    read_all(-1, 128);

    // k_num = 3 random data, in_valid every other cycle, readout paused mid-stream
    pulse_start(3'd3);
    for (int p = 0; p < 3; p++) send_poly(p, 5, 1'b1);
    finish_acc(132);
    push_model();
    read_all(40, 131);

    // k_num = 0 behaves as 1
    pulse_start(3'd0);
    send_poly(0, 6, 1'b0);
    finish_acc(132);
    push_model();
    read_all(-1, 128);

    // k_num = 7 behaves as 4
    pulse_start(3'd7);
    for (int p = 0; p < 4; p++) begin
      send_poly(p, 6, 1'b0);
      if (p < 3) check("in_ready after poly (k=7)", int'(in_ready), 1);
    end
    finish_acc(132);
    push_model();
    read_all(-1, 128);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
